// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops DWIDTH-bit words from a show-ahead FIFO and packs RATIO
// consecutive words into one wide valid/ready beat. Lane 0 holds the oldest word.
// A flush emits a partial beat with a contiguous lane-keep mask.
// Optional build macro FIFO_RD_PACKER_TIMEOUT_EN adds an idle-timeout auto-flush
// that fires TIMEOUT idle cycles after the last word of a partial beat.
module fifo_rd_packer #(
    parameter int DWIDTH  = 16,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [DWIDTH-1:0]        fifo_q_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rdreq_o,
    input  logic                     flush_i,
    output logic [DWIDTH*RATIO-1:0]  data_o,
    output logic [RATIO-1:0]         keep_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int CW = $clog2(RATIO + 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Reject illegal configurations at elaboration time.
    if (RATIO < 2 || RATIO > 16 || TIMEOUT < 1) begin : g_param_err
        $error("fifo_rd_packer: RATIO must be 2..16 and TIMEOUT >= 1");
    end

    logic [0:0]              state_q;
    logic [CW-1:0]           cnt_q;
    logic [DWIDTH*RATIO-1:0] data_q;
    logic [RATIO-1:0]        keep_q;

    logic take;
    logic last_lane;
    logic flush_eff;

    // Pop whenever a word is available and there is room: in FILL always,
    // in HOLD only when the pending beat leaves this cycle. Never while in reset.
    assign take = !srst_i && !fifo_empty_i &&
                  ((state_q == ST_FILL) || ((state_q == ST_HOLD) && ready_i));

    assign last_lane = (cnt_q == CW'(RATIO - 1));

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_q;
    logic          idle_run;
    logic          tmo_hit;

    assign idle_run = (state_q == ST_FILL) && (cnt_q != '0) && !take;
    assign tmo_hit  = idle_run && (idle_q == IW'(TIMEOUT - 1));
    assign flush_eff = flush_i || tmo_hit;

    // Idle counter: advances on idle cycles of a partial beat, cleared by any
    // take, by beat emission (explicit flush or timeout) and by reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            idle_q <= '0;
        end else if (idle_run && !flush_eff) begin
            idle_q <= idle_q + 1'b1;
        end else begin
            idle_q <= '0;
        end
    end
`else
    assign flush_eff = flush_i;
`endif

    // Packing state machine: fill lanes in FILL, present the beat in HOLD.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (take) begin
                        for (int i = 0; i < RATIO; i++) begin
                            if (cnt_q == CW'(i)) begin
                                data_q[DWIDTH*i +: DWIDTH] <= fifo_q_i;
                                keep_q[i]                  <= 1'b1;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        // The word taken with a flush is part of the emitted beat.
                        if (last_lane || flush_eff) begin
                            state_q <= ST_HOLD;
                        end
                    end else if (flush_eff && (cnt_q != '0)) begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    // Beat and mask stay frozen until the consumer accepts.
                    // A pop in the accepting cycle starts the next beat in lane 0.
                    if (ready_i) begin
                        state_q <= ST_FILL;
                        if (take) begin
                            cnt_q  <= CW'(1);
                            data_q <= {{(DWIDTH*(RATIO-1)){1'b0}}, fifo_q_i};
                            keep_q <= {{(RATIO-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_q  <= '0;
                            data_q <= '0;
                            keep_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign fifo_rdreq_o = take;
    assign valid_o      = (state_q == ST_HOLD);
    assign data_o       = data_q;
    assign keep_o       = keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: randomized and directed bench for fifo_rd_packer.
// A queue-based reference model tracks the words of the beat being built and
// whether a beat is pending; every cycle the DUT outputs are compared to it.
// Honours FIFO_RD_PACKER_TIMEOUT_EN the same way the design does.
module tb_fifo_rd_packer;

    localparam int DWIDTH  = 16;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;
    localparam int BW      = DWIDTH * RATIO;

    logic              clk = 1'b0;
    logic              srst;
    logic [DWIDTH-1:0] fifo_q;
    logic              fifo_empty;
    logic              fifo_rdreq;
    logic              flush;
    logic [BW-1:0]     data;
    logic [RATIO-1:0]  keep;
    logic              valid;
    logic              ready;

    always #5 clk = ~clk;

    fifo_rd_packer #(
        .DWIDTH (DWIDTH),
        .RATIO  (RATIO),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .fifo_q_i    (fifo_q),
        .fifo_empty_i(fifo_empty),
        .fifo_rdreq_o(fifo_rdreq),
        .flush_i     (flush),
        .data_o      (data),
        .keep_o      (keep),
        .valid_o     (valid),
        .ready_i     (ready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus-side FIFO contents and availability gap.
    logic [DWIDTH-1:0] fq[$];
    bit                gap;

    // Reference model: words of the beat under construction, pending flag.
    logic [DWIDTH-1:0] lanes[$];
    bit                pend;
    int                idle;
    bit                chk_en;

    // Observations of the last step.
    int                beats;
    logic [BW-1:0]     last_data;
    logic [RATIO-1:0]  last_keep;
    bit                saw_pop;
    bit                saw_vld;

    function automatic logic [BW-1:0] exp_data();
        logic [BW-1:0] d = '0;
        for (int i = 0; i < lanes.size(); i++) d[DWIDTH*i +: DWIDTH] = lanes[i];
        return d;
    endfunction

    function automatic logic [RATIO-1:0] exp_keep();
        logic [RATIO-1:0] k = '0;
        for (int i = 0; i < lanes.size(); i++) k[i] = 1'b1;
        return k;
    endfunction

    // One clock cycle: present FIFO, check outputs, advance model at the edge.
    task automatic step();
        bit                exp_rd;
        bit                fl;
        logic [DWIDTH-1:0] hw;
        fifo_empty = (fq.size() == 0) || gap;
        fifo_q     = (fq.size() > 0) ? fq[0] : 16'hDEAD;
        #1;
        exp_rd = !srst && !fifo_empty && (!pend || ready);
        if (chk_en) begin
            chk("valid", 64'(valid), 64'(pend));
            chk("data", 64'(data), 64'(exp_data()));
            chk("keep", 64'(keep), 64'(exp_keep()));
            chk("rdreq", 64'(fifo_rdreq), 64'(exp_rd));
        end
        saw_pop = exp_rd;
        saw_vld = valid;
        if (valid && ready) begin
            beats++;
            last_data = data;
            last_keep = keep;
        end
        hw = fifo_q;
        @(posedge clk);
        if (srst) begin
            lanes.delete();
            pend = 0;
            idle = 0;
        end else if (pend) begin
            if (ready) begin
                pend = 0;
                lanes.delete();
                if (exp_rd) lanes.push_back(hw);
                idle = 0;
            end
        end else begin
            fl = flush;
            if (exp_rd) begin
                idle = 0;
            end else if (lanes.size() > 0) begin
                idle++;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
                if (idle == TIMEOUT) fl = 1;
`endif
            end
            if (exp_rd) lanes.push_back(hw);
            if (lanes.size() == RATIO || (fl && lanes.size() > 0)) begin
                pend = 1;
                idle = 0;
            end
        end
        if (exp_rd && fq.size() > 0) void'(fq.pop_front());
        chk_en = 1;
        #1;
    endtask

    initial begin
        int idle_n;
        bit got;
        int b0;
        int npop;
        srst = 1; flush = 0; ready = 0; gap = 0;
        fifo_q = '0; fifo_empty = 1;
        pend = 0; idle = 0; chk_en = 0; beats = 0;
        last_data = '0; last_keep = '0;

        // Reset state.
        step(); step();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_keep", 64'(keep), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        srst = 0;

        // Four words make one full beat.
        ready = 1;
        fq.push_back(16'h1111); fq.push_back(16'h2222);
        fq.push_back(16'h3333); fq.push_back(16'h4444);
        b0 = beats;
        repeat (6) step();
        chk("t1_beats", 64'(beats - b0), 64'd1);
        chk("t1_data", 64'(last_data), 64'h4444_3333_2222_1111);
        chk("t1_keep", 64'(last_keep), 64'hF);

        // Eight words streamed back to back.
        for (int i = 0; i < 8; i++) fq.push_back(DWIDTH'(16'h5000 + i));
        b0 = beats; npop = 0;
        repeat (10) begin
            step();
            if (saw_pop) npop++;
        end
        chk("t2_pops", 64'(npop), 64'd8);
        chk("t2_beats", 64'(beats - b0), 64'd2);
        chk("t2_data", 64'(last_data), 64'h5007_5006_5005_5004);

        // Back-pressure holds the beat; accept pops in the same cycle.
        ready = 0;
        for (int i = 0; i < 6; i++) fq.push_back(DWIDTH'(16'h3000 + i));
        repeat (4) step();
        repeat (5) begin
            step();
            chk("t3_stable", 64'(data), 64'h3003_3002_3001_3000);
        end
        ready = 1;
        step();
        chk("t3_pop", 64'(saw_pop), 64'd1);
        chk("t3_keep", 64'(keep), 64'h1);
        step();
        flush = 1; step(); flush = 0;
        step();
        chk("t3_partial", 64'(last_data), 64'h0000_0000_3005_3004);

        // Explicit flush of two words, then flush with nothing collected.
        fq.push_back(16'hAAAA); fq.push_back(16'hBBBB);
        repeat (3) step();
        flush = 1; step(); flush = 0;
        step();
        chk("t4_data", 64'(last_data), 64'h0000_0000_BBBB_AAAA);
        chk("t4_keep", 64'(last_keep), 64'h3);
        b0 = beats;
        flush = 1; step(); flush = 0;
        repeat (3) step();
        chk("t4_empty_flush", 64'(beats - b0), 64'd0);

        // Idle timeout behaviour.
        fq.push_back(16'h0101); fq.push_back(16'h0202); fq.push_back(16'h0303);
        idle_n = 0; got = 0;
        for (int s = 0; s < 40 && !got; s++) begin
            step();
            if (saw_pop) idle_n = 0;
            else if (saw_vld) got = 1;
            else idle_n++;
        end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        chk("t5_seen", 64'(got), 64'd1);
        chk("t5_idle", 64'(idle_n), 64'(TIMEOUT));
        chk("t5_keep", 64'(last_keep), 64'h7);
        chk("t5_data", 64'(last_data), 64'h0000_0303_0202_0101);
`else
        chk("t5_no_beat", 64'(got), 64'd0);
        flush = 1; step(); flush = 0;
        step();
        chk("t5_flush_keep", 64'(last_keep), 64'h7);
`endif
        step();

        // Reset while a 2-lane beat is pending.
        ready = 0;
        fq.push_back(16'h6001); fq.push_back(16'h6002);
        step();
        flush = 1; step(); flush = 0;
        fq.push_back(16'h6003);
        step();
        srst = 1; step();
        chk("t6_hold_vld", 64'(valid), 64'd0);
        chk("t6_hold_keep", 64'(keep), 64'd0);
        chk("t6_hold_data", 64'(data), 64'd0);
        chk("t6_hold_rdreq", 64'(fifo_rdreq), 64'd0);
        srst = 0; fq.delete();
        // Reset while filling.
        ready = 1;
        fq.push_back(16'h7001); fq.push_back(16'h7002); fq.push_back(16'h7003);
        repeat (2) step();
        srst = 1; step();
        chk("t6_fill_keep", 64'(keep), 64'd0);
        chk("t6_fill_data", 64'(data), 64'd0);
        chk("t6_fill_rdreq", 64'(fifo_rdreq), 64'd0);
        srst = 0; fq.delete();
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            srst = ($urandom_range(0, 499) == 0);
            if (srst) fq.delete();
            if (fq.size() < 8 && ($urandom % 2) != 0) fq.push_back(DWIDTH'($urandom));
            gap   = (($urandom % 4) == 0);
            ready = (($urandom % 3) != 0);
            flush = (($urandom % 16) == 0);
            step();
        end
        srst = 0; gap = 0; ready = 1; flush = 0;
        repeat (20) step();
        flush = 1; step(); flush = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
